reg_list_sequencer: RTL and testbench
=====================================

// Module: reg_list_sequencer
// PURPOSE
// - Register-file initiator for block transfers (LDM/STM-style): walks a 16-bit register list and drives RW/PW/LE or the RB read port.
// - Moves each listed register to/from memory through a ready handshake, then optionally writes the final address back to the base register.
// - Sits between the control unit, the 16x32 register file (R15 = PC) and the data-memory port.
// PARAMETERS
// - DATA_W      32  width of data, address and register-file words
// - WORD_BYTES  4   address step per transferred register
// PORTS
// - Clk        in   1       rising-edge clock
// - Reset_n    in   1       asynchronous, active-low reset
// - Start      in   1       one-cycle request; sampled only in IDLE
// - IsLoad     in   1       1 = memory->registers, 0 = registers->memory
// - Up         in   1       1 = ascending addresses, 0 = descending
// - Before     in   1       1 = pre-index (step before first access), 0 = post-index
// - WB         in   1       write the final address back to Rn
// - Rn         in   4       base register number (writeback target)
// - RegList    in   16      bit i set => Ri is transferred
// - BaseAddr   in   DATA_W  value of Rn, sampled with Start
// - PuertoB    in   DATA_W  register-file read data for RB
// - MemRData   in   DATA_W  memory read data, valid when MemReady=1
// - MemReady   in   1       memory completes the current access this cycle
// - RB         out  4       register-file read select (stores)
// - RW         out  4       register-file write select
// - PW         out  DATA_W  register-file write data
// - LE         out  1       register-file write enable
// - MemAddr    out  DATA_W  word address of the current access
// - MemRead    out  1       read request; held until MemReady
// - MemWrite   out  1       write request; held until MemReady
// - MemWData   out  DATA_W  store data; equals PuertoB
// - Busy       out  1       high in ACCESS and WRITEBACK
// - Done       out  1       one-cycle completion pulse
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; latched list, address and flags cleared. Reset mid-transfer aborts immediately: no Done, no further LE.
// - States: IDLE -> ACCESS (Start, list != 0); IDLE -> DONE (Start, list == 0); ACCESS -> ACCESS (MemReady, bits remain);
//   ACCESS -> WRITEBACK (last MemReady, WB=1, and not (IsLoad and Rn in list)); ACCESS -> DONE (otherwise); WRITEBACK -> DONE; DONE -> IDLE.
// - Start while not IDLE is ignored. Start latches RegList, BaseAddr, IsLoad, Up, Before, WB and Rn.
// - N = popcount(RegList). First address: Up&!Before = Base; Up&Before = Base+4; !Up&!Before = Base-4N+4; !Up&Before = Base-4N.
// - Transfer order is ascending register number; the lowest register uses the lowest address; each completed access adds WORD_BYTES. Address arithmetic wraps modulo 2^DATA_W.
// - Final Rn value = Base+4N if Up, Base-4N if !Up.
// - ACCESS: cur = lowest set bit of the remaining mask.
//   - Store: RB=cur, MemWrite=1.
//   - Load: MemRead=1; in the MemReady cycle, LE=1, RW=cur and PW=MemRData, combinationally, so the register file captures on that edge.
//   - On MemReady, clear bit cur and advance the address. Wait states hold all outputs stable.
// - WRITEBACK: one cycle with LE=1, RW=Rn, PW=final address; no memory request.
// - If a load list contains Rn, the loaded value wins and there is no writeback. A store containing Rn stores the original Base.
// - A load into R15 is an ordinary RW=15 write; PC priority is handled by the register file.
// - Done is high for exactly the one DONE cycle; Busy=0 in DONE and IDLE. LE is never high outside the load MemReady cycle or WRITEBACK.
// STRUCTURE
// - Shared package: state encoding (IDLE, ACCESS, WRITEBACK, DONE), WORD_BYTES constant, 16-bit popcount function.
// - Sub-module lowest_set_bit_16: 16-bit mask -> 4-bit index plus valid flag (combinational).
// - Everything else (FSM, address register, mask register) lives in this file.
// TESTING
// - Load: list=16'h000E, Base=0x100, Up=1, Before=0, MemReady=1.
//   -> reads at 0x100/0x104/0x108; LE pulses with RW=1,2,3; Done in cycle 5.
// - Store: list=16'h8001, Base=0x200, Up=0, Before=1, WB=1, Rn=13.
//   -> writes R0@0x1F8, R15@0x1FC; WRITEBACK drives RW=13, PW=0x1F8.
// - Wait states: MemReady low 3 cycles per access.
//   -> MemAddr, MemRead and RB are stable throughout; LE only in ready cycles; no skipped register.
// - Empty list, WB=1. -> no memory request, no LE; Done one cycle after Start.
// - Load with Rn=2 in list, WB=1. -> R2 gets memory data; no WRITEBACK cycle.
// - Reset_n low mid-ACCESS, then Start during Busy.
//   -> outputs 0 and IDLE asynchronously; no Done; a Start while Busy is ignored.

Source files
------------

// File: rtl/reg_list_sequencer_pkg.sv
// Shared types and helpers for the register-list block-transfer sequencer.
// Pure definitions: no logic, no latency, no flow control.
package reg_list_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_list_sequencer_lowest_set_bit_16.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask, plus a valid flag.
// Combinational, zero latency; no flow control.
module lowest_set_bit_16
    import reg_list_sequencer_pkg::*;
(
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        vld
);

    // Scan from the top so the last hit, the lowest bit, wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// LDM/STM-style sequencer: moves listed registers to/from memory, then optional base writeback.
// One access per MemReady cycle; MemReady low stalls with all outputs held stable.
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              IsLoad,
    input  logic              Up,
    input  logic              Before,
    input  logic              WB,
    input  logic [3:0]        Rn,
    input  logic [15:0]       RegList,
    input  logic [DATA_W-1:0] BaseAddr,
    input  logic [DATA_W-1:0] PuertoB,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemReady,
    output logic [3:0]        RB,
    output logic [3:0]        RW,
    output logic [DATA_W-1:0] PW,
    output logic              LE,
    output logic [DATA_W-1:0] MemAddr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemWData,
    output logic              Busy,
    output logic              Done
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

    seq_state_t        state, state_nxt;
    logic [15:0]       mask;
    logic [15:0]       mask_rest;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] final_addr;
    logic              is_load;
    logic              do_wb;
    logic [3:0]        rn;
    logic [3:0]        cur;
    logic              cur_vld;
    logic [DATA_W-1:0] xfer_bytes;
    logic [DATA_W-1:0] first_addr;
    logic [DATA_W-1:0] end_addr;

    lowest_set_bit_16 u_lsb (
        .mask (mask),
        .idx  (cur),
        .vld  (cur_vld)
    );

    // Clearing the lowest set bit is all that advancing the walk needs.
    assign mask_rest  = mask & (mask - 16'd1);
    assign xfer_bytes = DATA_W'(popcount16(RegList)) * STEP;
    assign end_addr   = Up ? (BaseAddr + xfer_bytes) : (BaseAddr - xfer_bytes);

    // The block always occupies N ascending words; only its start moves with Up/Before.
    always_comb begin
        case ({Up, Before})
            2'b10:   first_addr = BaseAddr;
            2'b11:   first_addr = BaseAddr + STEP;
            2'b00:   first_addr = BaseAddr - xfer_bytes + STEP;
            default: first_addr = BaseAddr - xfer_bytes;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mask       <= '0;
            addr       <= '0;
            final_addr <= '0;
            is_load    <= 1'b0;
            do_wb      <= 1'b0;
            rn         <= '0;
        end else if (state == ST_IDLE && Start) begin
            mask       <= RegList;
            addr       <= first_addr;
            final_addr <= end_addr;
            is_load    <= IsLoad;
            // A load that refills Rn keeps the loaded value instead of the new base.
            do_wb      <= WB && !(IsLoad && RegList[Rn]);
            rn         <= Rn;
        end else if (state == ST_ACCESS && MemReady) begin
            mask <= mask_rest;
            addr <= addr + STEP;
        end
    end

    always_comb begin
        state_nxt = state;
        RB        = '0;
        RW        = '0;
        PW        = '0;
        LE        = 1'b0;
        MemAddr   = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemWData  = '0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt = (|RegList) ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                Busy    = 1'b1;
                MemAddr = addr;
                if (cur_vld) begin
                    if (is_load) begin
                        MemRead = 1'b1;
                        if (MemReady) begin
                            LE = 1'b1;
                            RW = cur;
                            PW = MemRData;
                        end
                    end else begin
                        MemWrite = 1'b1;
                        RB       = cur;
                        MemWData = PuertoB;
                    end
                end
                if (MemReady && !(|mask_rest)) begin
                    state_nxt = do_wb ? ST_WRITEBACK : ST_DONE;
                end
            end
            ST_WRITEBACK: begin
                Busy      = 1'b1;
                LE        = 1'b1;
                RW        = rn;
                PW        = final_addr;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Randomized bench for reg_list_sequencer: a transaction-level model predicts memory
// accesses, register writes and completion time from the command fields alone.
module tb_reg_list_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n, Start, IsLoad, Up, Before, WB, MemReady;
    logic [3:0]  Rn;
    logic [15:0] RegList;
    logic [31:0] BaseAddr, PuertoB, MemRData;
    logic [3:0]  RB, RW;
    logic [31:0] PW, MemAddr, MemWData;
    logic        LE, MemRead, MemWrite, Busy, Done;

    int checks = 0;
    int errors = 0;

    logic [31:0] regfile [16];

    // Expected and observed transactions
    logic [31:0] exp_acc_addr[$], exp_acc_data[$], exp_le_pw[$];
    logic [3:0]  exp_le_rw[$];
    int          exp_n, exp_wb;
    logic [31:0] obs_acc_addr[$], obs_acc_data[$], obs_le_pw[$];
    logic [3:0]  obs_le_rw[$];
    int          done_cyc, done_cnt, stab_bad, le_bad, busy_bad, total_waits;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
    endfunction

    assign MemRData = mem_val(MemAddr);
    assign PuertoB  = regfile[RB];

    reg_list_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .IsLoad(IsLoad), .Up(Up),
        .Before(Before), .WB(WB), .Rn(Rn), .RegList(RegList), .BaseAddr(BaseAddr),
        .PuertoB(PuertoB), .MemRData(MemRData), .MemReady(MemReady),
        .RB(RB), .RW(RW), .PW(PW), .LE(LE), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemWData(MemWData), .Busy(Busy), .Done(Done)
    );

    task automatic build_expected(input logic ld, input logic up, input logic bef, input logic wb,
                                  input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
        int n;
        logic [31:0] blk, first, fin, a;
        exp_acc_addr.delete(); exp_acc_data.delete(); exp_le_rw.delete(); exp_le_pw.delete();
        n   = $countones(list);
        blk = 32'(4 * n);
        fin = up ? base + blk : base - blk;
        if (up) first = bef ? base + 32'd4 : base;
        else    first = bef ? base - blk : base - blk + 32'd4;
        a = first;
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                exp_acc_addr.push_back(a);
                if (ld) begin
                    exp_acc_data.push_back(mem_val(a));
                    exp_le_rw.push_back(4'(r));
                    exp_le_pw.push_back(mem_val(a));
                end else begin
                    exp_acc_data.push_back((4'(r) == rn) ? base : regfile[r]);
                end
                a = a + 32'd4;
            end
        end
        exp_wb = (wb && list != 16'd0 && !(ld && list[rn])) ? 1 : 0;
        if (exp_wb == 1) begin
            exp_le_rw.push_back(rn);
            exp_le_pw.push_back(fin);
        end
        exp_n = n;
    endtask

    // Runs one command with a wait-state memory; wmode < 0 picks 0..2 waits per access.
    task automatic do_xfer(input logic ld, input logic up, input logic bef, input logic wb,
                           input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base,
                           input int wmode, input bit inject);
        int wleft;
        bit in_wait;
        logic [31:0] p_addr;
        logic [3:0]  p_rb;
        logic        p_rd, p_wr;
        obs_acc_addr.delete(); obs_acc_data.delete(); obs_le_rw.delete(); obs_le_pw.delete();
        done_cyc = 0; done_cnt = 0; stab_bad = 0; le_bad = 0; busy_bad = 0; total_waits = 0;
        in_wait = 1'b0; p_addr = '0; p_rb = '0; p_rd = 1'b0; p_wr = 1'b0;
        regfile[rn] = base;
        build_expected(ld, up, bef, wb, rn, list, base);
        wleft = (wmode < 0) ? $urandom_range(0, 2) : wmode;
        @(posedge Clk); #1;
        Start = 1'b1; IsLoad = ld; Up = up; Before = bef; WB = wb; Rn = rn;
        RegList = list; BaseAddr = base; MemReady = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc > 1) begin
                @(posedge Clk); #1;
                Start = inject && (cyc == 3);
                RegList  = Start ? ~list : list;
                BaseAddr = Start ? (base ^ 32'h5555_0000) : base;
                IsLoad   = Start ? ~ld : ld;
                if (MemRead || MemWrite) begin
                    if (wleft > 0) begin
                        MemReady = 1'b0;
                        wleft--;
                        total_waits++;
                    end else begin
                        MemReady = 1'b1;
                        wleft = (wmode < 0) ? $urandom_range(0, 2) : wmode;
                    end
                end else begin
                    MemReady = 1'($urandom_range(0, 1));
                end
            end
            @(negedge Clk);
            if (in_wait && (MemAddr !== p_addr || MemRead !== p_rd || MemWrite !== p_wr || RB !== p_rb))
                stab_bad++;
            in_wait = (MemRead || MemWrite) && !MemReady;
            p_addr = MemAddr; p_rd = MemRead; p_wr = MemWrite; p_rb = RB;
            if ((MemRead || MemWrite) && MemReady) begin
                obs_acc_addr.push_back(MemAddr);
                obs_acc_data.push_back(MemRead ? MemRData : MemWData);
            end
            if (LE) begin
                obs_le_rw.push_back(RW);
                obs_le_pw.push_back(PW);
                if (!(MemRead && MemReady) && (MemRead || MemWrite || !Busy)) le_bad++;
            end
            if (Busy && Done) busy_bad++;
            if (Done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc > done_cyc) break;
        end
        Start = 1'b0;
        MemReady = 1'b0;
    endtask

    task automatic test_reset();
        logic [108:0] v;
        Reset_n = 1'b0; Start = 1'b0; IsLoad = 1'b0; Up = 1'b0; Before = 1'b0; WB = 1'b0;
        Rn = '0; RegList = '0; BaseAddr = '0; MemReady = 1'b1;
        #12;
        v = {RB, RW, PW, LE, MemAddr, MemRead, MemWrite, MemWData, Busy, Done};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
        @(posedge Clk); #1; Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Busy, Done, LE, MemRead, MemWrite} !== 5'b0) begin
            errors++; $display("FAIL idle_after_reset got %b want 00000", {Busy, Done, LE, MemRead, MemWrite});
        end
    endtask

    task automatic test_load();
        logic [31:0] want_addr [3];
        want_addr[0] = 32'h100; want_addr[1] = 32'h104; want_addr[2] = 32'h108;
        do_xfer(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h000E, 32'h100, 0, 1'b0);
        checks++;
        if (done_cyc !== 5 || done_cnt !== 1) begin
            errors++; $display("FAIL load_done got cyc=%0d cnt=%0d want cyc=5 cnt=1", done_cyc, done_cnt);
        end
        checks++;
        if (obs_acc_addr.size() !== 3 || obs_le_rw.size() !== 3) begin
            errors++; $display("FAIL load_count got acc=%0d le=%0d want 3/3", obs_acc_addr.size(), obs_le_rw.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_acc_addr[k] !== want_addr[k] || obs_le_rw[k] !== 4'(k + 1) ||
                    obs_le_pw[k] !== mem_val(want_addr[k])) begin
                    errors++;
                    $display("FAIL load_beat%0d got addr=%h rw=%0d pw=%h want addr=%h rw=%0d pw=%h", k,
                             obs_acc_addr[k], obs_le_rw[k], obs_le_pw[k], want_addr[k], k + 1, mem_val(want_addr[k]));
                end
            end
        end
    endtask

    task automatic test_store();
        do_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8001, 32'h200, 0, 1'b0);
        checks++;
        if (obs_acc_addr.size() !== 2) begin
            errors++; $display("FAIL store_count got %0d want 2", obs_acc_addr.size());
        end else begin
            checks++;
            if (obs_acc_addr[0] !== 32'h1F8 || obs_acc_data[0] !== regfile[0] ||
                obs_acc_addr[1] !== 32'h1FC || obs_acc_data[1] !== regfile[15]) begin
                errors++;
                $display("FAIL store_beats got %h:%h %h:%h want 1f8:%h 1fc:%h", obs_acc_addr[0], obs_acc_data[0],
                         obs_acc_addr[1], obs_acc_data[1], regfile[0], regfile[15]);
            end
        end
        checks++;
        if (obs_le_rw.size() !== 1 || obs_le_rw[0] !== 4'd13 || obs_le_pw[0] !== 32'h1F8) begin
            errors++; $display("FAIL store_writeback got n=%0d rw=%0d pw=%h want n=1 rw=13 pw=1f8",
                               obs_le_rw.size(), obs_le_rw[0], obs_le_pw[0]);
        end
        checks++;
        if (done_cyc !== 5) begin errors++; $display("FAIL store_done got %0d want 5", done_cyc); end
    endtask

    task automatic test_wait_states();
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < 16; r++) regfile[r] = $urandom;
            do_xfer(1'(it), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 4'($urandom),
                    16'($urandom) | 16'h0101, $urandom, 3, 1'b0);
            checks++;
            if (stab_bad !== 0 || le_bad !== 0) begin
                errors++; $display("FAIL wait_stable it%0d got unstable=%0d bad_le=%0d want 0/0", it, stab_bad, le_bad);
            end
            checks++;
            if (obs_acc_addr != exp_acc_addr || obs_acc_data != exp_acc_data || obs_le_rw != exp_le_rw ||
                obs_le_pw != exp_le_pw) begin
                errors++; $display("FAIL wait_xfers it%0d got acc=%0d le=%0d want acc=%0d le=%0d", it,
                                   obs_acc_addr.size(), obs_le_rw.size(), exp_acc_addr.size(), exp_le_rw.size());
            end
            checks++;
            if (done_cyc !== 2 + 4 * exp_n + exp_wb) begin
                errors++; $display("FAIL wait_done it%0d got %0d want %0d", it, done_cyc, 2 + 4 * exp_n + exp_wb);
            end
        end
    endtask

    task automatic test_empty();
        do_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0000, 32'h400, -1, 1'b0);
        checks++;
        if (obs_acc_addr.size() !== 0 || obs_le_rw.size() !== 0 || done_cyc !== 2 || done_cnt !== 1) begin
            errors++; $display("FAIL empty_list got acc=%0d le=%0d cyc=%0d cnt=%0d want 0 0 2 1",
                               obs_acc_addr.size(), obs_le_rw.size(), done_cyc, done_cnt);
        end
    endtask

    task automatic test_rn_in_load();
        do_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0026, 32'h0000_3000, 0, 1'b0);
        checks++;
        if (obs_le_rw != exp_le_rw || obs_le_pw != exp_le_pw || obs_le_rw.size() !== 3) begin
            errors++; $display("FAIL rn_in_load got le=%0d want 3 (no writeback)", obs_le_rw.size());
        end
        checks++;
        if (done_cyc !== 5) begin errors++; $display("FAIL rn_in_load_done got %0d want 5", done_cyc); end
    endtask

    task automatic test_abort_reset();
        int bad;
        bad = 0;
        @(posedge Clk); #1;
        Start = 1'b1; IsLoad = 1'b1; Up = 1'b1; Before = 1'b0; WB = 1'b1; Rn = 4'd0;
        RegList = 16'h00F0; BaseAddr = 32'h800; MemReady = 1'b0;
        @(posedge Clk); #1; Start = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b1 || MemRead !== 1'b1) begin
            errors++; $display("FAIL abort_prep got busy=%b rd=%b want 1 1", Busy, MemRead);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, LE, MemRead, MemWrite, MemAddr} !== 37'd0) begin
            errors++; $display("FAIL abort_async got %h want 0", {Busy, Done, LE, MemRead, MemWrite, MemAddr});
        end
        @(posedge Clk); #1; Reset_n = 1'b1; MemReady = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            if (Done || LE || Busy || MemRead) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_start_while_busy();
        for (int r = 0; r < 16; r++) regfile[r] = $urandom;
        do_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 16'h0C30, 32'h0000_5000, 1, 1'b1);
        checks++;
        if (obs_acc_addr != exp_acc_addr || obs_acc_data != exp_acc_data || obs_le_rw != exp_le_rw ||
            obs_le_pw != exp_le_pw || done_cnt !== 1) begin
            errors++; $display("FAIL start_while_busy got acc=%0d le=%0d done=%0d want %0d %0d 1",
                               obs_acc_addr.size(), obs_le_rw.size(), done_cnt, exp_acc_addr.size(), exp_le_rw.size());
        end
    endtask

    task automatic test_random();
        logic [3:0]  rn;
        logic [15:0] list;
        for (int it = 0; it < 24; it++) begin
            for (int r = 0; r < 16; r++) regfile[r] = $urandom;
            rn   = 4'($urandom);
            list = (it % 6 == 0) ? 16'h0 : 16'($urandom);
            if (it % 5 == 0) list[rn] = 1'b1;
            do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), rn, list, $urandom, -1, 1'b0);
            checks++;
            if (obs_acc_addr != exp_acc_addr || obs_acc_data != exp_acc_data) begin
                errors++; $display("FAIL rand_mem it%0d got n=%0d want n=%0d", it, obs_acc_addr.size(), exp_acc_addr.size());
            end
            checks++;
            if (obs_le_rw != exp_le_rw || obs_le_pw != exp_le_pw) begin
                errors++; $display("FAIL rand_le it%0d got n=%0d want n=%0d", it, obs_le_rw.size(), exp_le_rw.size());
            end
            checks++;
            if (done_cyc !== 2 + exp_n + exp_wb + total_waits || done_cnt !== 1 || busy_bad !== 0 ||
                le_bad !== 0 || stab_bad !== 0) begin
                errors++; $display("FAIL rand_timing it%0d got cyc=%0d cnt=%0d want cyc=%0d cnt=1", it,
                                   done_cyc, done_cnt, 2 + exp_n + exp_wb + total_waits);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regfile[r] = $urandom;
        test_reset();
        test_load();
        test_store();
        test_wait_states();
        test_empty();
        test_rn_in_load();
        test_abort_reset();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
